// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch front end: opcodes, compressed-quadrant codes, FIFO entry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_queue_pkg;

    // 32-bit base opcodes that redirect control flow
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Compressed quadrants (inst[1:0])
    localparam logic [1:0] CQ_C1 = 2'b01;
    localparam logic [1:0] CQ_C2 = 2'b10;

    // Quadrant-1 funct3 codes (RV32: 001 is c.jal)
    localparam logic [2:0] C1_F3_JAL  = 3'b001;
    localparam logic [2:0] C1_F3_J    = 3'b101;
    localparam logic [2:0] C1_F3_BEQZ = 3'b110;
    localparam logic [2:0] C1_F3_BNEZ = 3'b111;

    // Quadrant-2 funct3 shared by c.jr / c.jalr / c.mv / c.add / c.ebreak
    localparam logic [2:0] C2_F3_JR   = 3'b100;

    // Two-bit counter reset value: weakly not-taken
    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        CF_NONE     = 2'd0,
        CF_JUMP     = 2'd1,
        CF_BRANCH   = 2'd2,
        CF_INDIRECT = 2'd3
    } cf_kind_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        is_c;
        logic [31:0] addr;
        logic [31:0] pred_addr;
        logic        pred_taken;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    // Saturating 2-bit counter step
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_queue_bht.sv
// Branch history table of 2-bit saturating counters, one combinational read, one update port.
// Latency: read is combinational; an update at edge N is visible to reads from cycle N+1.
// Backpressure: none; updates are dropped only while rdy_in is low (state hold).
//
// Ports: clk_in/rst_in clock and async active-low reset, rdy_in global hold,
//        rd_idx/rd_ctr lookup, upd_vld/upd_idx/upd_taken training.
module fetch_queue_bht
    import fetch_queue_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
    output logic [1:0]                     rd_ctr,
    input  logic                           upd_vld,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx,
    input  logic                           upd_taken
);

    logic [1:0] ctr [BHT_ENTRIES];

    // Same-cycle read of an index being updated returns the old value
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                ctr[i] <= BHT_INIT;
            end
        end else if (rdy_in && upd_vld) begin
            ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: issues fetches, predecodes control flow with a BHT, buffers entries for decode.
// Latency: an instruction accepted at edge N is at the FIFO head (if empty) in cycle N+1.
// Backpressure: if_enable drops when the FIFO is full, after a jalr (until melt) or on clear.
//
// Ports: clk_in/rst_in clock and async active-low reset; rdy_in freezes all state when low.
//        clear/corr_jump_addr flush and redirect; melt/melt_addr release a jalr freeze.
//        if_enable/if_addr fetch request; inst_ready/is_c/inst_val memory return.
//        upd_valid/upd_addr/upd_taken BHT training; out_* FIFO head; deq pop; count occupancy.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic [31:0]                  corr_jump_addr,
    input  logic                         melt,
    input  logic [31:0]                  melt_addr,
    output logic                         if_enable,
    output logic [31:0]                  if_addr,
    input  logic                         inst_ready,
    input  logic                         is_c,
    input  logic [31:0]                  inst_val,
    input  logic                         upd_valid,
    input  logic [31:0]                  upd_addr,
    input  logic                         upd_taken,
    output logic                         out_valid,
    output logic [31:0]                  out_inst,
    output logic                         out_is_c,
    output logic [31:0]                  out_addr,
    output logic [31:0]                  out_pred_addr,
    output logic                         out_pred_taken,
    input  logic                         deq,
    output logic [$clog2(QUEUE_DEPTH):0] count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]           pc;
    logic                  frozen;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [FQ_ENTRY_W-1:0] mem [QUEUE_DEPTH];

    logic                  accept;
    logic                  deq_fire;

    // ------------------------------------------------------------------
    // Fetch request: only registered state and clear feed if_enable, so a
    // full queue blocks accept even when the decoder pops in the same cycle.
    // ------------------------------------------------------------------
    assign if_enable = !frozen && (count < FULL_CNT) && !clear;
    assign if_addr   = pc;
    assign accept    = rdy_in && inst_ready && if_enable;
    assign out_valid = (count != '0);
    assign deq_fire  = rdy_in && !clear && deq && out_valid;

    // ------------------------------------------------------------------
    // Predecode
    // ------------------------------------------------------------------
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] imm_cj;
    logic [31:0] imm_cb;
    cf_kind_t    cf_kind;
    logic [31:0] offset;
    logic [31:0] seq_next;
    logic [31:0] tgt_addr;
    logic [31:0] pred_addr;
    logic        pred_taken;
    logic [1:0]  bht_ctr;

    assign imm_j  = {{12{inst_val[31]}}, inst_val[19:12], inst_val[20], inst_val[30:21], 1'b0};
    assign imm_b  = {{20{inst_val[31]}}, inst_val[7], inst_val[30:25], inst_val[11:8], 1'b0};
    assign imm_cj = {{21{inst_val[12]}}, inst_val[8], inst_val[10:9], inst_val[6], inst_val[7],
                     inst_val[2], inst_val[11], inst_val[5:3], 1'b0};
    assign imm_cb = {{24{inst_val[12]}}, inst_val[6:5], inst_val[2], inst_val[11:10],
                     inst_val[4:3], 1'b0};

    always_comb begin
        cf_kind = CF_NONE;
        offset  = 32'd0;
        if (is_c) begin
            if (inst_val[1:0] == CQ_C1) begin
                case (inst_val[15:13])
                    C1_F3_J, C1_F3_JAL: begin
                        cf_kind = CF_JUMP;
                        offset  = imm_cj;
                    end
                    C1_F3_BEQZ, C1_F3_BNEZ: begin
                        cf_kind = CF_BRANCH;
                        offset  = imm_cb;
                    end
                    default: begin
                        cf_kind = CF_NONE;
                    end
                endcase
            end else if (inst_val[1:0] == CQ_C2 && inst_val[15:13] == C2_F3_JR &&
                         inst_val[11:7] != 5'd0 && inst_val[6:2] == 5'd0) begin
                // c.jr (bit12=0) and c.jalr (bit12=1); rs1=0 would be reserved/c.ebreak
                cf_kind = CF_INDIRECT;
            end
        end else begin
            case (inst_val[6:0])
                OPC_JAL: begin
                    cf_kind = CF_JUMP;
                    offset  = imm_j;
                end
                OPC_JALR: begin
                    cf_kind = CF_INDIRECT;
                end
                OPC_BRANCH: begin
                    cf_kind = CF_BRANCH;
                    offset  = imm_b;
                end
                default: begin
                    cf_kind = CF_NONE;
                end
            endcase
        end
    end

    assign seq_next   = pc + (is_c ? 32'd2 : 32'd4);
    assign tgt_addr   = pc + offset;
    assign pred_taken = (cf_kind == CF_JUMP) || ((cf_kind == CF_BRANCH) && bht_ctr[1]);
    assign pred_addr  = pred_taken ? tgt_addr : seq_next;

    fetch_queue_bht #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rd_idx    (pc[IDX_W:1]),
        .rd_ctr    (bht_ctr),
        .upd_vld   (upd_valid),
        .upd_idx   (upd_addr[IDX_W:1]),
        .upd_taken (upd_taken)
    );

    // Only the index bits of upd_addr and the direction bit of the counter matter
    logic unused_bits;
    assign unused_bits = ^{upd_addr[31:IDX_W+1], upd_addr[0], bht_ctr[0]};

    // ------------------------------------------------------------------
    // PC and freeze. clear beats melt beats accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc     <= RESET_PC;
            frozen <= 1'b0;
        end else if (rdy_in) begin
            if (clear) begin
                pc     <= corr_jump_addr;
                frozen <= 1'b0;
            end else if (melt) begin
                pc     <= melt_addr;
                frozen <= 1'b0;
            end else if (accept) begin
                pc <= pred_addr;
                // Indirect target is unknown until the ROB resolves it
                if (cf_kind == CF_INDIRECT) begin
                    frozen <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (accept) begin
                    tail <= tail + PTR_W'(1);
                end
                if (deq_fire) begin
                    head <= head + PTR_W'(1);
                end
                case ({accept, deq_fire})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage has no reset; the head read is masked by out_valid instead
    fq_entry_t wr_ent;
    assign wr_ent = '{inst: inst_val, is_c: is_c, addr: pc, pred_addr: pred_addr,
                      pred_taken: pred_taken};

    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem[tail] <= wr_ent;
        end
    end

    fq_entry_t head_ent;
    assign head_ent = out_valid ? fq_entry_t'(mem[head]) : '0;

    assign out_inst       = head_ent.inst;
    assign out_is_c       = head_ent.is_c;
    assign out_addr       = head_ent.addr;
    assign out_pred_addr  = head_ent.pred_addr;
    assign out_pred_taken = head_ent.pred_taken;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table for straight-line fetch plus hand sequences.
// Latency: inputs driven 1ns after the rising edge, outputs checked before the next edge.
// Backpressure: scoreboard pops whenever the bench's deq meets a valid head.
`timescale 1ns/1ps
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BEQ20  = 32'h0200_0063;  // beq x0,x0,+0x20
    localparam logic [31:0] JAL4   = 32'h0040_00EF;  // jal x1,+4
    localparam logic [31:0] JALE   = 32'h00E0_006F;  // jal x0,+0xE
    localparam logic [31:0] JALR   = 32'h0000_8067;  // jalr x0,0(x1)
    localparam logic [31:0] CJM4   = 32'h0000_BFF5;  // c.j -4
    localparam logic [31:0] CADDI  = 32'h0000_0085;  // c.addi x1,1

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, melt, inst_ready, is_c, upd_valid, upd_taken, deq;
    logic [31:0] corr_jump_addr, melt_addr, inst_val, upd_addr;
    logic        if_enable, out_valid, out_is_c, out_pred_taken;
    logic [31:0] if_addr, out_inst, out_addr, out_pred_addr;
    logic [3:0]  count;

    fetch_queue #(.QUEUE_DEPTH(8), .BHT_ENTRIES(64), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .corr_jump_addr(corr_jump_addr), .melt(melt), .melt_addr(melt_addr),
        .if_enable(if_enable), .if_addr(if_addr), .inst_ready(inst_ready), .is_c(is_c),
        .inst_val(inst_val), .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .out_valid(out_valid), .out_inst(out_inst), .out_is_c(out_is_c), .out_addr(out_addr),
        .out_pred_addr(out_pred_addr), .out_pred_taken(out_pred_taken), .deq(deq), .count(count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    fq_entry_t sb[$];
    fq_entry_t exp_e, act_e;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        c;
        logic [31:0] next;
        logic        taken;
    } vec_t;
    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one returned instruction; the bench expects it to be accepted.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] inst,
                         input logic c, input logic [31:0] next, input logic tk);
        inst_ready = 1'b1;
        inst_val   = inst;
        is_c       = c;
        #2;
        chk({name, "_if_addr"}, if_addr, addr);
        chk({name, "_if_enable"}, 32'(if_enable), 32'd1);
        sb.push_back('{inst: inst, is_c: c, addr: addr, pred_addr: next, pred_taken: tk});
        @(posedge clk_in);
        #1;
        inst_ready = 1'b0;
        inst_val   = '0;
        is_c       = 1'b0;
    endtask

    task automatic melt_to(input logic [31:0] a);
        melt      = 1'b1;
        melt_addr = a;
        tick();
        melt = 1'b0;
        chk("melt_if_addr", if_addr, a);
    endtask

    task automatic upd(input logic [31:0] a, input logic t);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_taken = t;
        tick();
        upd_valid = 1'b0;
    endtask

    // Scoreboard: a pop happens on the coming edge when deq meets a valid head
    always @(negedge clk_in) begin
        if (rst_in && rdy_in) begin
            if (clear) begin
                sb.delete();
            end else if (deq && out_valid) begin
                act_e = '{inst: out_inst, is_c: out_is_c, addr: out_addr,
                          pred_addr: out_pred_addr, pred_taken: out_pred_taken};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: head addr %h with nothing expected", out_addr);
                end else begin
                    exp_e = sb.pop_front();
                    if (act_e !== exp_e) begin
                        errors++;
                        $display("FAIL sb_entry: got addr %h inst %h c %b pred %h tk %b expected addr %h inst %h c %b pred %h tk %b",
                                 act_e.addr, act_e.inst, act_e.is_c, act_e.pred_addr, act_e.pred_taken,
                                 exp_e.addr, exp_e.inst, exp_e.is_c, exp_e.pred_addr, exp_e.pred_taken);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{32'h00, NOP,   1'b0, 32'h04, 1'b0};
        vec[1] = '{32'h04, NOP,   1'b0, 32'h08, 1'b0};
        vec[2] = '{32'h08, NOP,   1'b0, 32'h0C, 1'b0};
        vec[3] = '{32'h0C, JAL4,  1'b0, 32'h10, 1'b1};
        vec[4] = '{32'h10, BEQ20, 1'b0, 32'h14, 1'b0};
        vec[5] = '{32'h14, JALE,  1'b0, 32'h22, 1'b1};
        vec[6] = '{32'h22, CJM4,  1'b1, 32'h1E, 1'b1};
        vec[7] = '{32'h1E, CADDI, 1'b1, 32'h20, 1'b0};
        vec[8] = '{32'h20, NOP,   1'b0, 32'h24, 1'b0};

        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; melt = 1'b0; inst_ready = 1'b0;
        is_c = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0; deq = 1'b0;
        corr_jump_addr = '0; melt_addr = '0; inst_val = '0; upd_addr = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_if_addr", if_addr, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_pred", out_pred_addr, 32'd0);
        chk("rst_out_flags", {30'd0, out_is_c, out_pred_taken}, 32'd0);
        rst_in = 1'b1;
        #1;
        chk("rst_if_enable", 32'(if_enable), 32'd1);

        // Straight-line stream with predecode, decoder always popping
        deq = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fetch("vec", vec[i].addr, vec[i].inst, vec[i].c, vec[i].next, vec[i].taken);
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_out_addr", out_addr, vec[i].addr);
        end
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // BHT: lookup sees pre-update value, then training flips the prediction
        melt_to(32'h10);
        upd_valid = 1'b1; upd_addr = 32'h10; upd_taken = 1'b1;
        fetch("bht_same_cyc", 32'h10, BEQ20, 1'b0, 32'h14, 1'b0);
        upd_valid = 1'b0;
        melt = 1'b1; melt_addr = 32'h10;
        upd(32'h10, 1'b1);
        melt = 1'b0;
        fetch("bht_taken", 32'h10, BEQ20, 1'b0, 32'h30, 1'b1);
        upd(32'h10, 1'b1);
        upd(32'h10, 1'b1);
        upd(32'h10, 1'b0);
        melt_to(32'h10);
        fetch("bht_sat_hi", 32'h10, BEQ20, 1'b0, 32'h30, 1'b1);
        upd(32'h10, 1'b0);
        upd(32'h10, 1'b0);
        upd(32'h10, 1'b0);
        melt_to(32'h10);
        fetch("bht_sat_lo", 32'h10, BEQ20, 1'b0, 32'h14, 1'b0);

        // jalr freezes fetch; a return while frozen is dropped; melt redirects
        melt_to(32'h40);
        fetch("jalr", 32'h40, JALR, 1'b0, 32'h44, 1'b0);
        #1;
        chk("frozen_if_enable", 32'(if_enable), 32'd0);
        inst_ready = 1'b1; inst_val = NOP;
        tick();
        inst_ready = 1'b0;
        chk("frozen_if_addr", if_addr, 32'h44);
        chk("frozen_count", 32'(count), 32'd0);
        melt = 1'b1; melt_addr = 32'h100;
        tick();
        melt = 1'b0;
        #1;
        chk("melt_if_addr2", if_addr, 32'h100);
        chk("melt_if_enable", 32'(if_enable), 32'd1);

        // Fill the queue with the decoder stalled
        deq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fetch("fill", 32'h100 + 32'(4 * i), NOP, 1'b0, 32'h104 + 32'(4 * i), 1'b0);
        end
        #1;
        chk("full_count", 32'(count), 32'd8);
        chk("full_if_enable", 32'(if_enable), 32'd0);
        chk("full_out_addr", out_addr, 32'h100);
        inst_ready = 1'b1; inst_val = NOP; deq = 1'b1;
        #1;
        chk("full_deq_if_enable", 32'(if_enable), 32'd0);
        tick();
        inst_ready = 1'b0; deq = 1'b0;
        #1;
        chk("pop_count", 32'(count), 32'd7);
        chk("pop_if_addr", if_addr, 32'h120);
        chk("pop_if_enable", 32'(if_enable), 32'd1);

        // rdy_in low holds everything, BHT included
        rdy_in = 1'b0; deq = 1'b1; inst_ready = 1'b1; inst_val = NOP;
        melt = 1'b1; melt_addr = 32'h300;
        upd_valid = 1'b1; upd_addr = 32'h200; upd_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_count", 32'(count), 32'd7);
            chk("hold_if_addr", if_addr, 32'h120);
            chk("hold_out_addr", out_addr, 32'h104);
        end
        rdy_in = 1'b1; deq = 1'b0; inst_ready = 1'b0; melt = 1'b0; upd_valid = 1'b0;

        // clear collides with accept, deq and a BHT update
        clear = 1'b1; corr_jump_addr = 32'h200;
        inst_ready = 1'b1; inst_val = NOP; deq = 1'b1;
        upd_valid = 1'b1; upd_addr = 32'h200; upd_taken = 1'b1;
        #1;
        chk("clear_if_enable", 32'(if_enable), 32'd0);
        tick();
        clear = 1'b0; inst_ready = 1'b0; upd_valid = 1'b0;
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_if_addr", if_addr, 32'h200);
        fetch("clear_bht", 32'h200, BEQ20, 1'b0, 32'h220, 1'b1);
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a cycle
        deq = 1'b0;
        fetch("pre_rst0", 32'h220, NOP, 1'b0, 32'h224, 1'b0);
        fetch("pre_rst1", 32'h224, NOP, 1'b0, 32'h228, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_if_addr", if_addr, 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        tick();
        rst_in = 1'b1;
        tick();
        chk("post_rst_if_addr", if_addr, 32'h0);
        chk("post_rst_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch front end that decouples instruction fetch from decode. It drives memctrl fetch requests and predecodes each returned 16/32-bit instruction for control flow. Next-PC comes from a 2-bit-counter branch history table (BHT), not always-taken. Fetched instructions are buffered in a FIFO that the decoder pops, and the block sits between memctrl and the decoder.

## Interface
Parameters:
- QUEUE_DEPTH, 8, FIFO entries; power of two, ≥2
- BHT_ENTRIES, 64, BHT counters; power of two, ≥2
- RESET_PC, 32'h0, PC loaded at reset

Ports:
- clk_in  in  1  system clock; all state on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  when low, all state holds (BHT updates included)
- clear  in  1  mispredict flush from ROB
- corr_jump_addr  in  32  redirect PC, valid with clear
- melt  in  1  jalr resolved; releases freeze
- melt_addr  in  32  jalr target, valid with melt
- if_enable  out  1  fetch request
- if_addr  out  32  fetch PC
- inst_ready  in  1  memctrl returns instruction for if_addr
- is_c  in  1  returned instruction is compressed
- inst_val  in  32  returned instruction; upper half ignored when is_c
- upd_valid  in  1  BHT training from ROB commit of a branch
- upd_addr  in  32  PC of the committed branch
- upd_taken  in  1  actual branch outcome
- out_valid  out  1  FIFO head valid
- out_inst  out  32  head instruction, raw
- out_is_c  out  1  head compressed flag
- out_addr  out  32  head PC
- out_pred_addr  out  32  predicted next PC of head
- out_pred_taken  out  1  head predicted taken (branch or jal)
- deq  in  1  decoder pops head; ignored when out_valid low
- count  out  $clog2(QUEUE_DEPTH)+1  current FIFO occupancy

## Operation
- State: pc, frozen, FIFO (head/tail pointers, count), BHT array of 2-bit counters.
- if_enable = !frozen && count < QUEUE_DEPTH && !clear. if_addr = pc.
- Accept: inst_ready && if_enable in the same cycle. inst_ready without if_enable is dropped, and pc is unchanged so the address is refetched.
- Predecode on accept:
  - jal: next = pc + imm_j, taken = 1.
  - c.j / c.jal: next = pc + CJ offset, taken = 1.
  - Branch (beq…bgeu) and c.beqz/c.bnez:
    - idx = pc[$clog2(BHT_ENTRIES):1].
    - taken = bht[idx][1].
    - next = taken ? pc + offset : pc + (is_c ? 2 : 4).
  - jalr, c.jr, c.jalr: enqueue, next = pc + (is_c ? 2 : 4), taken = 0, set frozen.
  - Others: next = pc + (is_c ? 2 : 4).
  - On accept: pc <= next, and the entry {inst, is_c, pc, next, taken} is written at tail.
- Dequeue: deq && out_valid advances head. Enqueue and dequeue in one cycle leaves count unchanged.
- BHT update: on upd_valid, counter at upd_addr index saturates +1 if taken, −1 otherwise (range 0..3).
  - A lookup in the same cycle on the same index reads the pre-update value.
- clear (priority 1):
  - count <= 0, head = tail = 0.
  - pc <= corr_jump_addr, frozen <= 0.
  - An accept in the same cycle is discarded.
  - A BHT update in the same cycle is still applied.
- melt (priority 2, ignored under clear): pc <= melt_addr, frozen <= 0. melt while not frozen still loads pc.
- All arithmetic is 32-bit modulo 2^32; offsets are sign-extended. Pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset values:
  - pc = RESET_PC, frozen = 0, count = 0, out_valid = 0.
  - All out_* = 0; if_enable = 1 after reset release.
  - All BHT counters = 2'b01 (weakly not-taken).
- Entry accepted at edge N is visible at the head (empty FIFO) after N; out_valid is high in cycle N+1.
- out_* are registered storage reads: head is stable until the deq edge, with no combinational path from inst_val.
- if_enable depends on registered count/frozen plus clear only, so count at QUEUE_DEPTH blocks accept even when deq is high that cycle.
- Redirect latency: clear or melt at edge N → if_addr = new PC in cycle N+1.
- BHT update at edge N affects predictions from cycle N+1.
- Reset asserted mid-operation returns everything to reset values asynchronously; pending inst_ready is lost.

## Structure
- Shared package: opcode localparams (jal, jalr, b), the compressed-quadrant funct3 codes, and the FIFO entry struct/width.
- Sub-module bht (parameter BHT_ENTRIES):
  - One combinational read port.
  - One synchronous saturating-update port.
  - Reset to 2'b01.
- FIFO and predecode inline.

## Test plan
- Sequential fetch: 3 non-control 32-bit instructions from RESET_PC=0, deq held high → if_addr 0,4,8; out_addr 0,4,8 each one cycle after accept.
- Branch prediction: beq at 0x10, offset +0x20:
  - Fresh BHT → out_pred_addr 0x14, taken 0.
  - Two upd_taken=1 for 0x10, then refetch → out_pred_addr 0x30, taken 1.
  - Four updates with upd_taken=1 saturate the counter at 3.
- Full queue: deq=0 for QUEUE_DEPTH accepts → count=QUEUE_DEPTH, if_enable=0. One deq → count drops by one and if_enable returns next cycle.
- jalr freeze: jalr at 0x40 → frozen, if_enable=0. melt with melt_addr=0x100 → if_addr 0x100 next cycle.
- Clear collision:
  - Stimulus: clear (corr_jump_addr=0x200) in the same cycle as inst_ready, deq and an upd_valid.
  - Response: count=0, out_valid=0, if_addr=0x200, and the BHT counter still updated.
- Compressed: c.j offset −4 at 0x22 → out_pred_addr 0x1E. c.addi at 0x1E → next 0x20. rdy_in low for 3 cycles → no state change.
